// File: rtl/pid_gain_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// pid_gain_cfg_ctrl
//   Parses ASCII frames "<KP>,<KI>,<KD>\n" from a byte-level UART receiver,
//   checks syntax and range, and holds the three new gains in a shadow set.
//   The shadow set is committed to the PID datapath atomically on a
//   pid_sample pulse, so the loop never sees a mix of old and new gains.
//   Rejected frames, timeouts and dropped bytes are reported on cfg_err and
//   err_code.
//
// Ports
//   clk_50m     : system clock
//   rst         : synchronous, active-high reset
//   rx_data     : received byte, valid while rx_valid=1
//   rx_valid    : one-cycle strobe per received byte
//   pid_sample  : one-cycle pulse at each PID loop update boundary
//   KP, KI, KD  : committed gains (registered)
//   cfg_update  : pulses in the cycle the new gains become visible
//   cfg_err     : pulses in the cycle after a rejected frame / dropped byte
//   err_code    : cause of last error (1 syntax, 2 range, 3 timeout, 4 overrun)
//   busy        : high while parsing, pending a commit, or discarding
// -----------------------------------------------------------------------------
module pid_gain_cfg_ctrl #(
  parameter int GAIN_W      = 6,
  parameter int MAX_DIGITS  = 3,
  parameter int TIMEOUT_CYC = 43400,
  parameter int DEF_KP      = 3,
  parameter int DEF_KI      = 1,
  parameter int DEF_KD      = 5
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              pid_sample,
  output logic [GAIN_W-1:0] KP,
  output logic [GAIN_W-1:0] KI,
  output logic [GAIN_W-1:0] KD,
  output logic              cfg_update,
  output logic              cfg_err,
  output logic [2:0]        err_code,
  output logic              busy
);

  localparam int ACC_W  = 10;
  localparam int NDIG_W = $clog2(MAX_DIGITS + 1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ACC_W-1:0] MAX_GAIN = ACC_W'((1 << GAIN_W) - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PARSE   = 2'd1;
  localparam logic [1:0] S_PEND    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam logic [2:0] E_SYNTAX  = 3'd1;
  localparam logic [2:0] E_RANGE   = 3'd2;
  localparam logic [2:0] E_TIMEOUT = 3'd3;
  localparam logic [2:0] E_OVERRUN = 3'd4;

  logic [1:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [NDIG_W-1:0] ndig_q, ndig_d;
  logic [1:0]        fld_q, fld_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [GAIN_W-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [GAIN_W-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic              upd_q, upd_d;
  logic              err_q, err_d;
  logic [2:0]        code_q, code_d;

  logic is_dig, is_sep, is_lf, is_cr, tmo;

  assign is_dig = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_sep = (rx_data == 8'h2C);
  assign is_lf  = (rx_data == 8'h0A);
  assign is_cr  = (rx_data == 8'h0D);
  // Last idle cycle allowed inside a frame; the timer restarts on every byte.
  assign tmo    = !rx_valid && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ndig_d  = ndig_q;
    fld_d   = fld_q;
    tmr_d   = '0;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    kp_d    = kp_q;
    ki_d    = ki_q;
    kd_d    = kd_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (is_dig) begin
            state_d = S_PARSE;
            fld_d   = 2'd0;
            acc_d   = ACC_W'(rx_data[3:0]);
            ndig_d  = NDIG_W'(1);
          end else if (!is_lf && !is_cr) begin
            err_d   = 1'b1;
            code_d  = E_SYNTAX;
            state_d = S_DISCARD;
          end
        end
      end

      S_PARSE: begin
        if (!rx_valid) begin
          tmr_d = tmr_q + TMR_W'(1);
          if (tmo) begin
            err_d   = 1'b1;
            code_d  = E_TIMEOUT;
            state_d = S_IDLE;
          end
        end else if (is_cr) begin
          // CR is transparent but still counts as line activity.
        end else if (is_dig) begin
          if (ndig_q == NDIG_W'(MAX_DIGITS)) begin
            err_d   = 1'b1;
            code_d  = E_SYNTAX;
            state_d = S_DISCARD;
          end else begin
            // Three decimal digits top out at 999, which fits in ACC_W bits.
            acc_d  = acc_q * ACC_W'(10) + ACC_W'(rx_data[3:0]);
            ndig_d = ndig_q + NDIG_W'(1);
          end
        end else if (is_sep) begin
          if (ndig_q == '0 || fld_q == 2'd2) begin
            err_d   = 1'b1;
            code_d  = E_SYNTAX;
            state_d = S_DISCARD;
          end else if (acc_q > MAX_GAIN) begin
            err_d   = 1'b1;
            code_d  = E_RANGE;
            state_d = S_DISCARD;
          end else begin
            if (fld_q == 2'd0) sh0_d = acc_q[GAIN_W-1:0];
            else               sh1_d = acc_q[GAIN_W-1:0];
            fld_d  = fld_q + 2'd1;
            acc_d  = '0;
            ndig_d = '0;
          end
        end else if (is_lf) begin
          // The terminator closes the frame, so errors here return to IDLE
          // rather than waiting for another LF in DISCARD.
          if (fld_q != 2'd2 || ndig_q == '0) begin
            err_d   = 1'b1;
            code_d  = E_SYNTAX;
            state_d = S_IDLE;
          end else if (acc_q > MAX_GAIN) begin
            err_d   = 1'b1;
            code_d  = E_RANGE;
            state_d = S_IDLE;
          end else begin
            sh2_d   = acc_q[GAIN_W-1:0];
            state_d = S_PEND;
          end
        end else begin
          err_d   = 1'b1;
          code_d  = E_SYNTAX;
          state_d = S_DISCARD;
        end
      end

      S_PEND: begin
        if (rx_valid && !is_cr) begin
          err_d  = 1'b1;
          code_d = E_OVERRUN;
        end
        if (pid_sample) begin
          kp_d    = sh0_q;
          ki_d    = sh1_q;
          kd_d    = sh2_q;
          upd_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin // S_DISCARD
        if (rx_valid) begin
          if (is_lf) state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
          if (tmo) state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ndig_q  <= '0;
      fld_q   <= '0;
      tmr_q   <= '0;
      kp_q    <= GAIN_W'(DEF_KP);
      ki_q    <= GAIN_W'(DEF_KI);
      kd_q    <= GAIN_W'(DEF_KD);
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ndig_q  <= ndig_d;
      fld_q   <= fld_d;
      tmr_q   <= tmr_d;
      kp_q    <= kp_d;
      ki_q    <= ki_d;
      kd_q    <= kd_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Shadow gains are pure data; they are only read after a complete frame.
  always_ff @(posedge clk_50m) begin
    sh0_q <= sh0_d;
    sh1_q <= sh1_d;
    sh2_q <= sh2_d;
  end

  assign KP         = kp_q;
  assign KI         = ki_q;
  assign KD         = kd_q;
  assign cfg_update = upd_q;
  assign cfg_err    = err_q;
  assign err_code   = code_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pid_gain_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pid_gain_cfg_ctrl
//   Directed frame table, hand-written multi-cycle sequences and a randomized
//   byte stream compared cycle by cycle against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_pid_gain_cfg_ctrl;

  localparam int TO = 64;

  logic       clk_50m;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       pid_sample;
  logic [5:0] KP, KI, KD;
  logic       cfg_update, cfg_err, busy;
  logic [2:0] err_code;

  int nvec = 0;
  int nbad = 0;
  int nerr_seen = 0;
  int nupd_seen = 0;

  pid_gain_cfg_ctrl #(
    .GAIN_W(6), .MAX_DIGITS(3), .TIMEOUT_CYC(TO),
    .DEF_KP(3), .DEF_KI(1), .DEF_KD(5)
  ) dut (
    .clk_50m(clk_50m), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .pid_sample(pid_sample), .KP(KP), .KI(KI), .KD(KD),
    .cfg_update(cfg_update), .cfg_err(cfg_err), .err_code(err_code), .busy(busy)
  );

  initial clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  always @(negedge clk_50m) begin
    if (cfg_err)    nerr_seen = nerr_seen + 1;
    if (cfg_update) nupd_seen = nupd_seen + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nbad = nbad + 1;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      tick();
    end
  endtask

  task automatic pulse_sample();
    pid_sample = 1'b1;
    tick();
    pid_sample = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    string      frm;
    logic [5:0] kp, ki, kd;
    logic [2:0] code;
    int         nerr;
    int         nupd;
  } vec_t;

  vec_t tbl[12];

  // ---------------------------------------------------------------- model
  localparam int M_IDLE = 0, M_FRAME = 1, M_PEND = 2, M_DROP = 3;
  int         m_mode;
  int         m_flds[$];
  int         m_cur, m_nd;
  int         m_kp, m_ki, m_kd;
  logic       m_upd, m_err;
  logic [2:0] m_code;

  function automatic logic [23:0] model_out();
    return {m_kp[5:0], m_ki[5:0], m_kd[5:0], m_upd, m_err, m_code, (m_mode != M_IDLE)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_flds.delete(); m_cur = 0; m_nd = 0;
    m_kp = 3; m_ki = 1; m_kd = 5; m_upd = 0; m_err = 0; m_code = 0;
  endtask

  task automatic reject(input logic [2:0] c, input int next_mode);
    m_err = 1; m_code = c; m_mode = next_mode;
  endtask

  // Applies one cycle of inputs; outputs are what should appear after the edge.
  task automatic model_step(input logic v, input logic [7:0] b, input logic s);
    bit dig;
    dig = (b >= "0" && b <= "9");
    m_upd = 0;
    m_err = 0;
    case (m_mode)
      M_IDLE:
        if (v) begin
          if (dig) begin
            m_mode = M_FRAME; m_flds.delete(); m_cur = int'(b) - 48; m_nd = 1;
          end else if (b != 8'h0A && b != 8'h0D) reject(1, M_DROP);
        end
      M_FRAME:
        if (v && b != 8'h0D) begin
          if (dig) begin
            if (m_nd == 3) reject(1, M_DROP);
            else begin m_cur = m_cur * 10 + int'(b) - 48; m_nd++; end
          end else if (b == ",") begin
            if (m_nd == 0 || m_flds.size() == 2) reject(1, M_DROP);
            else if (m_cur > 63) reject(2, M_DROP);
            else begin m_flds.push_back(m_cur); m_cur = 0; m_nd = 0; end
          end else if (b == 8'h0A) begin
            if (m_flds.size() != 2 || m_nd == 0) reject(1, M_IDLE);
            else if (m_cur > 63) reject(2, M_IDLE);
            else begin m_flds.push_back(m_cur); m_mode = M_PEND; end
          end else reject(1, M_DROP);
        end
      M_PEND: begin
        if (v && b != 8'h0D) begin m_err = 1; m_code = 4; end
        if (s) begin
          m_kp = m_flds[0]; m_ki = m_flds[1]; m_kd = m_flds[2];
          m_upd = 1; m_mode = M_IDLE;
        end
      end
      default:
        if (v && b == 8'h0A) m_mode = M_IDLE;
    endcase
  endtask

  logic [7:0] bq[$];

  task automatic gen_frame();
    int nf, nd;
    nf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 3;
    for (int f = 0; f < nf; f++) begin
      nd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : $urandom_range(1, 2);
      for (int d = 0; d < nd; d++) bq.push_back(8'(8'h30 + $urandom_range(0, 9)));
      if ($urandom_range(0, 24) == 0) bq.push_back(($urandom_range(0, 1) == 0) ? 8'h78 : 8'h3A);
      if ($urandom_range(0, 14) == 0) bq.push_back(8'h0D);
      if (f < nf - 1) bq.push_back(8'h2C);
    end
    bq.push_back(8'h0A);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    int b0, u0, n, gap;
    bit got;

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; pid_sample = 1'b0;

    tbl[0]  = '{"12,3,45\n",        6'd12, 6'd3,  6'd45, 3'd0, 0, 1};
    tbl[1]  = '{"70,1,1\n",         6'd12, 6'd3,  6'd45, 3'd2, 1, 0};
    tbl[2]  = '{"1,2\n",            6'd12, 6'd3,  6'd45, 3'd1, 1, 0};
    tbl[3]  = '{"1234,5,6\n",       6'd12, 6'd3,  6'd45, 3'd1, 1, 0};
    tbl[4]  = '{"0,63,7\015\n",     6'd0,  6'd63, 6'd7,  3'd1, 0, 1};
    tbl[5]  = '{",1,2\n",           6'd0,  6'd63, 6'd7,  3'd1, 1, 0};
    tbl[6]  = '{"1,2,3,4\n",        6'd0,  6'd63, 6'd7,  3'd1, 1, 0};
    tbl[7]  = '{"5,6,64\n",         6'd0,  6'd63, 6'd7,  3'd2, 1, 0};
    tbl[8]  = '{"\n",               6'd0,  6'd63, 6'd7,  3'd2, 0, 0};
    tbl[9]  = '{"007,08,9\n",       6'd7,  6'd8,  6'd9,  3'd2, 0, 1};
    tbl[10] = '{"1,,2\n",           6'd7,  6'd8,  6'd9,  3'd1, 1, 0};
    tbl[11] = '{"1a,2,3\n",         6'd7,  6'd8,  6'd9,  3'd1, 1, 0};

    do_reset();
    chk("reset_state", {KP, KI, KD, cfg_update, cfg_err, err_code, busy},
        {6'd3, 6'd1, 6'd5, 1'b0, 1'b0, 3'd0, 1'b0});

    // Directed frame table
    foreach (tbl[i]) begin
      b0 = nerr_seen; u0 = nupd_seen;
      send_str(tbl[i].frm);
      idle(3);
      pulse_sample();
      idle(3);
      chk($sformatf("tbl%0d_state", i), {KP, KI, KD, err_code, busy},
          {tbl[i].kp, tbl[i].ki, tbl[i].kd, tbl[i].code, 1'b0});
      chk($sformatf("tbl%0d_errs", i), nerr_seen - b0, tbl[i].nerr);
      chk($sformatf("tbl%0d_upds", i), nupd_seen - u0, tbl[i].nupd);
    end

    // Commit timing: one cfg_update, in the cycle after the sample
    send_str("20,21,22\n");
    idle(2);
    chk("pend_hold", {KP, KI, KD, busy}, {6'd7, 6'd8, 6'd9, 1'b1});
    pulse_sample();
    chk("commit_cycle", {cfg_update, KP, KI, KD}, {1'b1, 6'd20, 6'd21, 6'd22});
    tick();
    chk("commit_after", {cfg_update, busy}, {1'b0, 1'b0});

    // pid_sample coinciding with LF does not commit
    u0 = nupd_seen;
    send_str("1,2,3");
    rx_data = 8'h0A; rx_valid = 1'b1; pid_sample = 1'b1;
    tick();
    rx_valid = 1'b0; pid_sample = 1'b0;
    idle(3);
    chk("lf_sample_nocommit", {KP, busy, 6'(nupd_seen - u0)}, {6'd20, 1'b1, 6'd0});
    pulse_sample();
    idle(1);
    chk("lf_sample_later", {KP, KI, KD}, {6'd1, 6'd2, 6'd3});

    // Timeout inside a frame
    send_str("5,");
    send_byte("6");
    n = 0; got = 0;
    for (int k = 1; k <= 3 * TO && !got; k++) begin
      if (cfg_err) begin got = 1; n = k; end
      else tick();
    end
    chk("timeout_seen", {31'd0, got}, 32'd1);
    chk("timeout_window", {31'd0, (n >= TO - 2 && n <= TO + 2)}, 32'd1);
    chk("timeout_code", {err_code, busy, KP}, {3'd3, 1'b0, 6'd1});
    idle(2);
    send_str("7,8,9\n");
    pulse_sample();
    chk("after_timeout", {KP, KI, KD}, {6'd7, 6'd8, 6'd9});

    // Overrun while pending; commit still happens
    send_str("1,2,3\n");
    send_byte("x");
    chk("overrun_err", {cfg_err, err_code, busy}, {1'b1, 3'd4, 1'b1});
    idle(2);
    pulse_sample();
    chk("overrun_commit", {KP, KI, KD, cfg_update}, {6'd1, 6'd2, 6'd3, 1'b1});

    // Overrun byte in the commit cycle: both pulses together
    send_str("4,5,6\n");
    idle(2);
    rx_data = "y"; rx_valid = 1'b1; pid_sample = 1'b1;
    tick();
    rx_valid = 1'b0; pid_sample = 1'b0;
    chk("both_pulse", {cfg_update, cfg_err, err_code, KP, KI, KD},
        {1'b1, 1'b1, 3'd4, 6'd4, 6'd5, 6'd6});

    // Reset while pending discards the frame
    send_str("9,9,9\n");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_pend", {KP, KI, KD, cfg_update, cfg_err, err_code, busy},
        {6'd3, 6'd1, 6'd5, 1'b0, 1'b0, 3'd0, 1'b0});
    u0 = nupd_seen;
    pulse_sample();
    idle(2);
    chk("rst_pend_nocommit", {KP, KI, KD, 6'(nupd_seen - u0)}, {6'd3, 6'd1, 6'd5, 6'd0});

    // Timeout in DISCARD returns to IDLE silently
    send_str("ab");
    b0 = nerr_seen;
    idle(TO + 10);
    chk("discard_timeout", {busy, 6'(nerr_seen - b0)}, {1'b0, 6'd0});
    send_str("2,3,4\n");
    pulse_sample();
    chk("discard_recover", {KP, KI, KD}, {6'd2, 6'd3, 6'd4});

    // Randomized stream against the reference model
    do_reset();
    model_reset();
    gap = 0;
    for (int c = 0; c < 4000; c++) begin
      rx_valid = 1'b0;
      pid_sample = ($urandom_range(0, 5) == 0);
      if (gap == 0) begin
        if (bq.size() == 0) gen_frame();
        rx_data  = bq.pop_front();
        rx_valid = 1'b1;
        gap = $urandom_range(0, 4);
      end else gap--;
      model_step(rx_valid, rx_data, pid_sample);
      tick();
      chk($sformatf("rand_c%0d", c),
          {8'd0, KP, KI, KD, cfg_update, cfg_err, err_code, busy},
          {8'd0, model_out()});
    end
    rx_valid = 1'b0; pid_sample = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
